// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: captures the fetched word into IR, decodes it and
// sequences FETCH/DECODE/EXE/MEM/WB, driving PC-select, register-file, ALU and memory controls.
module mc_ctrl #(
    parameter int unsigned ILLEGAL_TRAP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        pc_we,
    output logic        npc_sel,
    output logic        j_sel,
    output logic        jr_sel,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic [1:0]  ext_op,
    output logic        mem_we,
    output logic [1:0]  mem_to_reg,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExe    = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        InsAddu,
        InsSubu,
        InsJr,
        InsOri,
        InsLui,
        InsLw,
        InsSw,
        InsBeq,
        InsJ,
        InsJal,
        InsIll
    } ins_e;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;

    ins_e        ins;
    logic [1:0]  dec_alu_op;
    logic        dec_alu_src;
    logic [1:0]  dec_ext_op;
    logic        alu_en;

    // Only opcode and funct steer the controller; the operand fields feed the datapath.
    logic unused_ir;
    assign unused_ir = ^ir_q[25:6];

    always_comb begin
        ins = InsIll;
        case (ir_q[31:26])
            6'b000000: begin
                case (ir_q[5:0])
                    6'b100001: ins = InsAddu;
                    6'b100011: ins = InsSubu;
                    6'b001000: ins = InsJr;
                    default:   ins = InsIll;
                endcase
            end
            6'b001101: ins = InsOri;
            6'b001111: ins = InsLui;
            6'b100011: ins = InsLw;
            6'b101011: ins = InsSw;
            6'b000100: ins = InsBeq;
            6'b000010: ins = InsJ;
            6'b000011: ins = InsJal;
            default:   ins = InsIll;
        endcase
    end

    always_comb begin
        dec_alu_op  = 2'd0;
        dec_alu_src = 1'b0;
        dec_ext_op  = 2'd0;
        case (ins)
            InsAddu: begin
                dec_alu_op = 2'd0;
                dec_ext_op = 2'd1;
            end
            InsLw, InsSw: begin
                dec_alu_op  = 2'd0;
                dec_alu_src = 1'b1;
                dec_ext_op  = 2'd1;
            end
            InsSubu, InsBeq: begin
                dec_alu_op  = 2'd1;
                dec_alu_src = 1'b0;
            end
            InsOri: begin
                dec_alu_op  = 2'd2;
                dec_alu_src = 1'b1;
                dec_ext_op  = 2'd0;
            end
            InsLui: begin
                dec_alu_op  = 2'd3;
                dec_alu_src = 1'b1;
                dec_ext_op  = 2'd2;
            end
            default: begin
                dec_alu_op  = 2'd0;
                dec_alu_src = 1'b0;
                dec_ext_op  = 2'd0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        alu_en     = 1'b0;
        pc_we      = 1'b0;
        npc_sel    = 1'b0;
        j_sel      = 1'b0;
        jr_sel     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 2'd0;
        mem_we     = 1'b0;
        mem_to_reg = 2'd0;
        illegal    = 1'b0;

        case (state_q)
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                case (ins)
                    InsJ: begin
                        pc_we   = 1'b1;
                        j_sel   = 1'b1;
                        state_d = StFetch;
                    end
                    InsJr: begin
                        pc_we   = 1'b1;
                        jr_sel  = 1'b1;
                        state_d = StFetch;
                    end
                    InsJal: begin
                        state_d = StWb;
                    end
                    InsIll: begin
                        if (ILLEGAL_TRAP != 0) begin
                            state_d = StHalt;
                        end else begin
                            pc_we   = 1'b1;
                            state_d = StFetch;
                        end
                    end
                    default: begin
                        state_d = StExe;
                    end
                endcase
            end
            StExe: begin
                alu_en = 1'b1;
                case (ins)
                    InsBeq: begin
                        pc_we   = 1'b1;
                        npc_sel = 1'b1;
                        state_d = StFetch;
                    end
                    InsLw, InsSw: state_d = StMem;
                    default:      state_d = StWb;
                endcase
            end
            StMem: begin
                alu_en = 1'b1;
                case (ins)
                    InsLw: state_d = StWb;
                    InsSw: begin
                        mem_we  = 1'b1;
                        pc_we   = 1'b1;
                        state_d = StFetch;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StWb: begin
                alu_en  = 1'b1;
                pc_we   = 1'b1;
                reg_we  = 1'b1;
                state_d = StFetch;
                case (ins)
                    InsJal: begin
                        // Link value is PC+4 of the jal itself, so the PC must not move before WB.
                        j_sel      = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                    InsLw: begin
                        reg_dst    = 2'd0;
                        mem_to_reg = 2'd1;
                    end
                    InsAddu, InsSubu: reg_dst = 2'd1;
                    default:          reg_dst = 2'd0;
                endcase
            end
            StHalt: begin
                illegal = 1'b1;
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        alu_op  = alu_en ? dec_alu_op : 2'd0;
        alu_src = alu_en ? dec_alu_src : 1'b0;
        ext_op  = alu_en ? dec_ext_op : 2'd0;

        // Reset aborts whatever is in flight, so nothing may strobe in that cycle.
        if (reset) begin
            pc_we      = 1'b0;
            npc_sel    = 1'b0;
            j_sel      = 1'b0;
            jr_sel     = 1'b0;
            reg_we     = 1'b0;
            reg_dst    = 2'd0;
            mem_we     = 1'b0;
            mem_to_reg = 2'd0;
            illegal    = 1'b0;
            alu_op     = 2'd0;
            alu_src    = 1'b0;
            ext_op     = 2'd0;
        end
    end

    always_comb begin
        ir_d      = (state_q == StFetch) ? instr : ir_q;
        retired_d = retired_q + {31'd0, pc_we};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign state   = reset ? 3'd0 : state_q;
    assign retired = reset ? 32'd0 : retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: one trapping and one skipping instance share the stimulus;
// every cycle's control bundle is compared against hand-written expectations.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_we;
        logic       npc_sel;
        logic       j_sel;
        logic       jr_sel;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] ext_op;
        logic       mem_we;
        logic [1:0] mem_to_reg;
        logic       illegal;
    } ctl_t;

    localparam logic [31:0] AddU   = 32'h0022_1821;
    localparam logic [31:0] SubU   = 32'h0022_1823;
    localparam logic [31:0] OriI   = 32'h3422_0005;
    localparam logic [31:0] LuiI   = 32'h3C02_1234;
    localparam logic [31:0] LwI    = 32'h8C22_0004;
    localparam logic [31:0] SwI    = 32'hAC22_0008;
    localparam logic [31:0] BeqI   = 32'h1022_0003;
    localparam logic [31:0] JI     = 32'h0800_0C01;
    localparam logic [31:0] JalI   = 32'h0C00_0C01;
    localparam logic [31:0] JrI    = 32'h03E0_0008;
    localparam logic [31:0] BadOp  = 32'hFC00_0000;
    localparam logic [31:0] BadFn  = 32'h0022_1820;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;

    logic        t_pc_we, t_npc_sel, t_j_sel, t_jr_sel, t_reg_we, t_alu_src, t_mem_we, t_illegal;
    logic [1:0]  t_reg_dst, t_alu_op, t_ext_op, t_mem_to_reg;
    logic [2:0]  t_state;
    logic [31:0] t_retired;
    logic        s_pc_we, s_npc_sel, s_j_sel, s_jr_sel, s_reg_we, s_alu_src, s_mem_we, s_illegal;
    logic [1:0]  s_reg_dst, s_alu_op, s_ext_op, s_mem_to_reg;
    logic [2:0]  s_state;
    logic [31:0] s_retired;

    ctl_t t_obs, s_obs;
    assign t_obs = {t_state, t_pc_we, t_npc_sel, t_j_sel, t_jr_sel, t_reg_we, t_reg_dst,
                    t_alu_src, t_alu_op, t_ext_op, t_mem_we, t_mem_to_reg, t_illegal};
    assign s_obs = {s_state, s_pc_we, s_npc_sel, s_j_sel, s_jr_sel, s_reg_we, s_reg_dst,
                    s_alu_src, s_alu_op, s_ext_op, s_mem_we, s_mem_to_reg, s_illegal};

    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_ret = 32'd0;

    always #5 clk = ~clk;

    mc_ctrl #(.ILLEGAL_TRAP(1)) dut_trap (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .pc_we      (t_pc_we),
        .npc_sel    (t_npc_sel),
        .j_sel      (t_j_sel),
        .jr_sel     (t_jr_sel),
        .reg_we     (t_reg_we),
        .reg_dst    (t_reg_dst),
        .alu_src    (t_alu_src),
        .alu_op     (t_alu_op),
        .ext_op     (t_ext_op),
        .mem_we     (t_mem_we),
        .mem_to_reg (t_mem_to_reg),
        .state      (t_state),
        .illegal    (t_illegal),
        .retired    (t_retired)
    );

    mc_ctrl #(.ILLEGAL_TRAP(0)) dut_skip (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .pc_we      (s_pc_we),
        .npc_sel    (s_npc_sel),
        .j_sel      (s_j_sel),
        .jr_sel     (s_jr_sel),
        .reg_we     (s_reg_we),
        .reg_dst    (s_reg_dst),
        .alu_src    (s_alu_src),
        .alu_op     (s_alu_op),
        .ext_op     (s_ext_op),
        .mem_we     (s_mem_we),
        .mem_to_reg (s_mem_to_reg),
        .state      (s_state),
        .illegal    (s_illegal),
        .retired    (s_retired)
    );

    // Argument order follows the ctl_t field order.
    function automatic ctl_t mk(input int st, input int pcw, input int npc, input int js,
                                input int jrs, input int rwe, input int rdst, input int asrc,
                                input int aop, input int eop, input int mwe, input int m2r,
                                input int ill);
        mk = {3'(st), 1'(pcw), 1'(npc), 1'(js), 1'(jrs), 1'(rwe), 2'(rdst), 1'(asrc),
              2'(aop), 2'(eop), 1'(mwe), 2'(m2r), 1'(ill)};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if (t_obs !== ctl_t'(0) || t_retired !== 32'd0)
                $display("FAIL reset_cycle%0d: got ctl=%h ret=%0d want ctl=0 ret=0",
                         i, t_obs, t_retired);
            else passes++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (t_obs !== ctl_t'(0)) $display("FAIL reset_release: got %h want 0", t_obs);
        else passes++;
    endtask

    // Register-type ALU path: FETCH, DECODE, EXE, WB, back to FETCH.
    task automatic test_alu(input string name, input logic [31:0] ins, input int aop,
                            input int asrc, input int eop, input int rdst);
        ctl_t exp [5];
        exp[0] = ctl_t'(0);
        exp[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp[2] = mk(2, 0, 0, 0, 0, 0, 0, asrc, aop, eop, 0, 0, 0);
        exp[3] = mk(4, 1, 0, 0, 0, 1, rdst, asrc, aop, eop, 0, 0, 0);
        exp[4] = ctl_t'(0);
        instr = ins;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++;
            if (t_obs !== exp[i]) $display("FAIL %s_c%0d: got %h want %h", name, i, t_obs, exp[i]);
            else passes++;
        end
        exp_ret = exp_ret + 32'd1;
        checks++;
        if (t_retired !== exp_ret)
            $display("FAIL %s_retired: got %0d want %0d", name, t_retired, exp_ret);
        else passes++;
    endtask

    task automatic test_load_store();
        ctl_t lw_exp [6];
        ctl_t sw_exp [5];
        lw_exp[0] = ctl_t'(0);
        lw_exp[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw_exp[2] = mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        lw_exp[3] = mk(3, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        lw_exp[4] = mk(4, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0);
        lw_exp[5] = ctl_t'(0);
        sw_exp[0] = ctl_t'(0);
        sw_exp[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sw_exp[2] = mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        sw_exp[3] = mk(3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        sw_exp[4] = ctl_t'(0);
        instr = LwI;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++;
            if (t_obs !== lw_exp[i]) $display("FAIL lw_c%0d: got %h want %h", i, t_obs, lw_exp[i]);
            else passes++;
        end
        instr = SwI;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++;
            if (t_obs !== sw_exp[i]) $display("FAIL sw_c%0d: got %h want %h", i, t_obs, sw_exp[i]);
            else passes++;
        end
        exp_ret = exp_ret + 32'd2;
        checks++;
        if (t_retired !== exp_ret)
            $display("FAIL ldst_retired: got %0d want %0d", t_retired, exp_ret);
        else passes++;
    endtask

    task automatic test_branch();
        ctl_t exp [4];
        exp[0] = ctl_t'(0);
        exp[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp[2] = mk(2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        exp[3] = ctl_t'(0);
        instr = BeqI;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++;
            if (t_obs !== exp[i]) $display("FAIL beq_c%0d: got %h want %h", i, t_obs, exp[i]);
            else passes++;
        end
        exp_ret = exp_ret + 32'd1;
    endtask

    task automatic test_jumps();
        ctl_t j_exp [3];
        ctl_t jal_exp [4];
        ctl_t jr_exp [3];
        j_exp[0]   = ctl_t'(0);
        j_exp[1]   = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        j_exp[2]   = ctl_t'(0);
        jal_exp[0] = ctl_t'(0);
        jal_exp[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        jal_exp[2] = mk(4, 1, 0, 1, 0, 1, 2, 0, 0, 0, 0, 2, 0);
        jal_exp[3] = ctl_t'(0);
        jr_exp[0]  = ctl_t'(0);
        jr_exp[1]  = mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        jr_exp[2]  = ctl_t'(0);
        instr = JI;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++;
            if (t_obs !== j_exp[i]) $display("FAIL j_c%0d: got %h want %h", i, t_obs, j_exp[i]);
            else passes++;
        end
        instr = JalI;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++;
            if (t_obs !== jal_exp[i]) $display("FAIL jal_c%0d: got %h want %h", i, t_obs, jal_exp[i]);
            else passes++;
        end
        instr = JrI;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++;
            if (t_obs !== jr_exp[i]) $display("FAIL jr_c%0d: got %h want %h", i, t_obs, jr_exp[i]);
            else passes++;
        end
        exp_ret = exp_ret + 32'd3;
        checks++;
        if (t_retired !== exp_ret)
            $display("FAIL jump_retired: got %0d want %0d", t_retired, exp_ret);
        else passes++;
    endtask

    // Trap instance halts; skip instance retires the bad opcode then a bad R-type funct.
    task automatic test_illegal();
        ctl_t s_exp [5];
        ctl_t t_exp;
        s_exp[0] = ctl_t'(0);
        s_exp[1] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s_exp[2] = ctl_t'(0);
        s_exp[3] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s_exp[4] = ctl_t'(0);
        instr = BadOp;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            if (i == 0) t_exp = ctl_t'(0);
            else if (i == 1) t_exp = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            else t_exp = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            checks++;
            if (t_obs !== t_exp) $display("FAIL trap_c%0d: got %h want %h", i, t_obs, t_exp);
            else passes++;
            if (i < 5) begin
                checks++;
                if (s_obs !== s_exp[i])
                    $display("FAIL skip_c%0d: got %h want %h", i, s_obs, s_exp[i]);
                else passes++;
            end
            if (i == 4) begin
                checks++;
                if (s_retired !== exp_ret + 32'd2)
                    $display("FAIL skip_retired: got %0d want %0d", s_retired, exp_ret + 32'd2);
                else passes++;
            end
            if (i == 2) instr = BadFn;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (t_obs !== ctl_t'(0)) $display("FAIL halt_reset: got %h want 0", t_obs);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_ret = 32'd0;
        checks++;
        if (t_obs !== ctl_t'(0) || t_retired !== exp_ret)
            $display("FAIL halt_recover: got ctl=%h ret=%0d want ctl=0 ret=0", t_obs, t_retired);
        else passes++;
    endtask

    task automatic test_reset_in_mem();
        ctl_t exp [3];
        exp[0] = ctl_t'(0);
        exp[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp[2] = mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        instr = LwI;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            checks++;
            if (t_obs !== exp[i]) $display("FAIL abort_lw_c%0d: got %h want %h", i, t_obs, exp[i]);
            else passes++;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (t_obs !== ctl_t'(0) || t_reg_we !== 1'b0)
            $display("FAIL abort_mem_cycle: got %h want 0", t_obs);
        else passes++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_ret = 32'd0;
        checks++;
        if (t_obs !== ctl_t'(0) || t_retired !== exp_ret)
            $display("FAIL abort_after: got ctl=%h ret=%0d want ctl=0 ret=0", t_obs, t_retired);
        else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu("addu", AddU, 0, 0, 1, 1);
        test_load_store();
        test_branch();
        test_jumps();
        test_alu("subu", SubU, 1, 0, 0, 1);
        test_alu("ori", OriI, 2, 1, 0, 0);
        test_alu("lui", LuiI, 3, 1, 2, 0);
        test_illegal();
        test_reset_in_mem();
        test_alu("addu_after_abort", AddU, 0, 0, 1, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
